// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch requester: one aligned ICCM read per cycle, epoch-tagged, into a small queue.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.

module ifu_fetch_ctrl_chk #(
    parameter int CW      = 3,
    parameter int Q_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_s,
    input  logic [CW-1:0] count_s
);

    // A push into a full queue means the issue credit check was bypassed
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_s && (count_s == CW'(Q_DEPTH))));

endmodule

module ifu_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    WIDTH      = 32,
    parameter int                    TAG_WIDTH  = 2,
    parameter int                    Q_DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] iccm_raddr,
    output logic                  iccm_req_valid,
    output logic [TAG_WIDTH-1:0]  iccm_req_tag,
    input  logic [WIDTH-1:0]      iccm_rdata,
    input  logic                  iccm_rsp_valid,
    input  logic [TAG_WIDTH-1:0]  iccm_rsp_tag,
    output logic                  instr_valid,
    output logic [WIDTH-1:0]      instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_drop_cnt
`endif
);

    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] inflight_pc_r;
    logic [TAG_WIDTH-1:0]  epoch_r;
    logic                  inflight_r;
    logic [CW-1:0]         count_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [WIDTH-1:0]      q_data_r [Q_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_r   [Q_DEPTH];

    logic                  credit_ok_s;
    logic                  issue_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  unused_s;

    // Issue/accept/pop qualifiers; a redirect blocks all three in its own cycle
    always_comb begin
        credit_ok_s = (count_r + CW'(inflight_r)) < CW'(Q_DEPTH);
        issue_s     = ~rst & fetch_en & ~redirect_valid & credit_ok_s;
        accept_s    = iccm_rsp_valid & inflight_r & (iccm_rsp_tag == epoch_r) & ~redirect_valid;
        pop_s       = (count_r != {CW{1'b0}}) & instr_ready & ~redirect_valid;
        unused_s    = ^redirect_pc[1:0];
    end

    assign iccm_req_valid = issue_s;
    assign iccm_raddr     = pc_r;
    assign iccm_req_tag   = epoch_r;
    assign instr_valid    = (count_r != {CW{1'b0}});
    assign instr          = q_data_r[rd_ptr_r];
    assign instr_pc       = q_pc_r[rd_ptr_r];

    // Fetch pointer, epoch, in-flight tracking and queue occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_pc_r <= {ADDR_WIDTH{1'b0}};
            epoch_r       <= {TAG_WIDTH{1'b0}};
            inflight_r    <= 1'b0;
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
        end else if (redirect_valid) begin
            pc_r       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            epoch_r    <= epoch_r + TAG_WIDTH'(1'b1);
            inflight_r <= 1'b0;
            count_r    <= {CW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
        end else begin
            if (issue_s) begin
                pc_r          <= pc_r + ADDR_WIDTH'(3'd4);
                inflight_r    <= 1'b1;
                inflight_pc_r <= pc_r;
            end else begin
                inflight_r <= 1'b0;
            end
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_data_r[i] <= {WIDTH{1'b0}};
                q_pc_r[i]   <= {ADDR_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            q_data_r[wr_ptr_r] <= iccm_rdata;
            q_pc_r[wr_ptr_r]   <= inflight_pc_r;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Free-running event counters, untouched by redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_drop_cnt  <= 32'd0;
        end else begin
            if (issue_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (iccm_rsp_valid && !accept_s) begin
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
            end
        end
    end
`endif

    ifu_fetch_ctrl_chk #(
        .CW      (CW),
        .Q_DEPTH (Q_DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .push_s  (accept_s),
        .count_s (count_r)
    );

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a 1-cycle ICCM model returning 0x1000 + word index.
// Define FETCH_PERF_CNT_EN to also check the perf counters.

module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic [11:0] iccm_raddr;
    logic        iccm_req_valid;
    logic [1:0]  iccm_req_tag;
    logic [31:0] iccm_rdata;
    logic        iccm_rsp_valid;
    logic [1:0]  iccm_rsp_tag;
    logic        instr_valid;
    logic [31:0] instr;
    logic [11:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    logic        mdl_valid_r;
    logic [1:0]  mdl_tag_r;
    logic [31:0] mdl_data_r;
    logic        inj_en;
    logic        inj_valid;
    logic [1:0]  inj_tag;
    logic [31:0] inj_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .iccm_raddr     (iccm_raddr),
        .iccm_req_valid (iccm_req_valid),
        .iccm_req_tag   (iccm_req_tag),
        .iccm_rdata     (iccm_rdata),
        .iccm_rsp_valid (iccm_rsp_valid),
        .iccm_rsp_tag   (iccm_rsp_tag),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
`endif
    );

    // ICCM model: fixed 1-cycle latency, word i holds 0x1000 + i
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_valid_r <= 1'b0;
            mdl_tag_r   <= 2'd0;
            mdl_data_r  <= 32'd0;
        end else begin
            mdl_valid_r <= iccm_req_valid;
            mdl_tag_r   <= iccm_req_tag;
            mdl_data_r  <= 32'h1000 + 32'(iccm_raddr >> 2);
        end
    end

    assign iccm_rsp_valid = inj_en ? inj_valid : mdl_valid_r;
    assign iccm_rsp_tag   = inj_en ? inj_tag   : mdl_tag_r;
    assign iccm_rdata     = inj_en ? inj_data  : mdl_data_r;

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'h000;
        instr_ready = 1'b0; inj_en = 1'b0; inj_valid = 1'b0; inj_tag = 2'd0; inj_data = 32'd0;
        repeat (2) @(negedge clk);
        fetch_en = 1'b1;
        #1;
        total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", iccm_req_valid); end
        total++; if (iccm_raddr !== 12'h000) begin bad++; $display("FAIL reset_raddr got=%h want=000", iccm_raddr); end
        total++; if (iccm_req_tag !== 2'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", iccm_req_tag); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b want=0", instr_valid); end
        total++; if (instr !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
        total++; if (instr_pc !== 12'h000) begin bad++; $display("FAIL reset_instr_pc got=%h want=000", instr_pc); end
    endtask

    task automatic test_stream();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; end
            #1;
            total++; if (iccm_req_valid !== 1'b1 || iccm_raddr !== 12'(c * 4)) begin bad++; $display("FAIL stream_req c=%0d got=%b/%h want=1/%h", c, iccm_req_valid, iccm_raddr, 12'(c * 4)); end
            if (c < 2) begin
                total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got=%b want=0", c, instr_valid); end
            end else begin
                total++; if (instr_valid !== 1'b1 || instr !== 32'h1000 + 32'(c - 2) || instr_pc !== 12'((c - 2) * 4)) begin
                    bad++; $display("FAIL stream_head c=%0d got=%b/%h/%h want=1/%h/%h", c, instr_valid, instr, instr_pc, 32'h1000 + 32'(c - 2), 12'((c - 2) * 4));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'h100; instr_ready = 1'b0;
        #1;
        total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL bp_redirect_noissue got=%b want=0", iccm_req_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            if (iccm_req_valid === 1'b1) issued++;
        end
        total++; if (issued != 4) begin bad++; $display("FAIL bp_issue_count got=%0d want=4", issued); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h100 || instr !== 32'h1040) begin
            bad++; $display("FAIL bp_full_head got=%b/%h/%h want=1/100/1040", instr_valid, instr_pc, instr);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            if (i == 0) begin
                total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL bp_no_pop_credit got=%b want=0", iccm_req_valid); end
            end
            total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h100 + 12'(i * 4) || instr !== 32'h1040 + 32'(i)) begin
                bad++; $display("FAIL bp_drain i=%0d got=%b/%h/%h want=1/%h/%h", i, instr_valid, instr_pc, instr, 12'h100 + 12'(i * 4), 32'h1040 + 32'(i));
            end
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'h042;
        #1;
        total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL redir_noissue got=%b want=0", iccm_req_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            #1;
            total++; if (iccm_req_valid !== 1'b1 || iccm_raddr !== 12'h040 + 12'(i * 4) || iccm_req_tag !== 2'd2) begin
                bad++; $display("FAIL redir_req i=%0d got=%b/%h/%0d want=1/%h/2", i, iccm_req_valid, iccm_raddr, iccm_req_tag, 12'h040 + 12'(i * 4));
            end
            if (i < 2) begin
                total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed i=%0d got=%b want=0", i, instr_valid); end
            end else begin
                total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h040 || instr !== 32'h1010) begin
                    bad++; $display("FAIL redir_first got=%b/%h/%h want=1/040/1010", instr_valid, instr_pc, instr);
                end
            end
        end
    endtask

    task automatic test_drop();
        @(negedge clk);
        fetch_en = 1'b0; instr_ready = 1'b0;
        #1;
        total++; if (iccm_req_valid !== 1'b0 || iccm_raddr !== 12'h04C) begin bad++; $display("FAIL drop_frozen got=%b/%h want=0/04c", iccm_req_valid, iccm_raddr); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h044) begin bad++; $display("FAIL drop_head0 got=%b/%h want=1/044", instr_valid, instr_pc); end
        @(negedge clk);
        fetch_en = 1'b1;
        #1;
        total++; if (iccm_req_valid !== 1'b1 || iccm_raddr !== 12'h04C) begin bad++; $display("FAIL drop_issue got=%b/%h want=1/04c", iccm_req_valid, iccm_raddr); end
        @(negedge clk);
        fetch_en = 1'b0; inj_en = 1'b1; inj_valid = 1'b1; inj_tag = 2'd1; inj_data = 32'hDEAD_BEEF;
        @(negedge clk);
        inj_tag = 2'd2;
        @(negedge clk);
        inj_en = 1'b0; inj_valid = 1'b0; instr_ready = 1'b1;
        #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h044 || instr !== 32'h1011) begin bad++; $display("FAIL drop_q0 got=%b/%h/%h want=1/044/1011", instr_valid, instr_pc, instr); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h048 || instr !== 32'h1012) begin bad++; $display("FAIL drop_q1 got=%b/%h/%h want=1/048/1012", instr_valid, instr_pc, instr); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL drop_no_stale got=%b/%h want=0", instr_valid, instr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_drop_cnt !== 32'd4) begin bad++; $display("FAIL perf_drop got=%0d want=4", perf_drop_cnt); end
        total++; if (perf_fetch_cnt !== 32'd23) begin bad++; $display("FAIL perf_fetch got=%0d want=23", perf_fetch_cnt); end
`endif
    endtask

    task automatic test_pc_wrap();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'hFFF; fetch_en = 1'b1;
        #1;
        total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL wrap_noissue got=%b want=0", iccm_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (iccm_req_valid !== 1'b1 || iccm_raddr !== 12'hFFC || iccm_req_tag !== 2'd3) begin
            bad++; $display("FAIL wrap_req0 got=%b/%h/%0d want=1/ffc/3", iccm_req_valid, iccm_raddr, iccm_req_tag);
        end
        @(negedge clk); #1;
        total++; if (iccm_raddr !== 12'h000) begin bad++; $display("FAIL wrap_req1 got=%h want=000", iccm_raddr); end
        @(negedge clk); #1;
        total++; if (iccm_raddr !== 12'h004) begin bad++; $display("FAIL wrap_req2 got=%h want=004", iccm_raddr); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'hFFC || instr !== 32'h13FF) begin bad++; $display("FAIL wrap_head0 got=%b/%h/%h want=1/ffc/13ff", instr_valid, instr_pc, instr); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h000 || instr !== 32'h1000) begin bad++; $display("FAIL wrap_head1 got=%b/%h/%h want=1/000/1000", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (iccm_req_valid !== 1'b0 || iccm_raddr !== 12'h000 || iccm_req_tag !== 2'd0) begin
            bad++; $display("FAIL mid_rst_req got=%b/%h/%0d want=0/000/0", iccm_req_valid, iccm_raddr, iccm_req_tag);
        end
        total++; if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 12'h000) begin
            bad++; $display("FAIL mid_rst_q got=%b/%h/%h want=0/0/000", instr_valid, instr, instr_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetch_cnt !== 32'd0 || perf_drop_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_perf got=%0d/%0d want=0/0", perf_fetch_cnt, perf_drop_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0; fetch_en = 1'b0;
        #1;
        total++; if (iccm_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_idle got=%b/%b want=0/0", iccm_req_valid, instr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] pcs [4];
        pcs = '{12'h100, 12'h200, 12'h300, 12'h3A4};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            redirect_valid = 1'b1; redirect_pc = pcs[i]; fetch_en = 1'b1;
            #1;
            total++; if (iccm_req_valid !== 1'b0) begin bad++; $display("FAIL b2b_noissue i=%0d got=%b want=0", i, iccm_req_valid); end
            if (i == 3) begin
                total++; if (iccm_req_tag !== 2'd3) begin bad++; $display("FAIL b2b_epoch3 got=%0d want=3", iccm_req_tag); end
            end
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++; if (iccm_req_valid !== 1'b1 || iccm_raddr !== 12'h3A4 || iccm_req_tag !== 2'd0) begin
            bad++; $display("FAIL b2b_req got=%b/%h/%0d want=1/3a4/0", iccm_req_valid, iccm_raddr, iccm_req_tag);
        end
        @(negedge clk); #1;
        total++; if (iccm_raddr !== 12'h3A8 || instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_second got=%h/%b want=3a8/0", iccm_raddr, instr_valid); end
        @(negedge clk); #1;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 12'h3A4 || instr !== 32'h10E9) begin
            bad++; $display("FAIL b2b_head got=%b/%h/%h want=1/3a4/10e9", instr_valid, instr_pc, instr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_drop();
        test_pc_wrap();
        test_reset_midstream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
